// File: rtl/mem_arbiter_pkg.sv
// Shared command and state encodings for the lab RAM arbiter and its requesters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_RDATA = 1'b1
    } arb_state_e;

    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes to prio.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt_vec,
    output logic       winner
);

    assign winner = (&req) ? prio : req[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt_vec[gi] = req[gi] & (winner == 1'(gi));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port lab RAM between the CPU (port 0) and the loader (port 1);
// writes take one cycle, reads two because the RAM read is registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    p0_cmd,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    input  logic [1:0]    p1_cmd,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          err
);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          prio_q, prio_d;
    logic          err_q, err_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;

    logic [1:0]    req;
    logic [1:0]    gnt_vec;
    logic          winner;
    logic [1:0]    win_cmd;

    assign req = {is_req(p1_cmd), is_req(p0_cmd)};

    rr_pick2 u_pick (
        .req     (req),
        .prio    (prio_q),
        .gnt_vec (gnt_vec),
        .winner  (winner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        err_d      = err_q | (p0_cmd == MILLEGAL) | (p1_cmd == MILLEGAL);
        ram_addr_d = ram_addr_q;
        win_cmd    = MNONE;
        p0_gnt     = 1'b0;
        p1_gnt     = 1'b0;
        p0_rvalid  = 1'b0;
        p1_rvalid  = 1'b0;
        ram_we     = 1'b0;
        ram_din    = '0;
        busy       = 1'b0;

        // Reset wins over everything, including a read in flight.
        if (reset) begin
            state_d = S_IDLE;
            owner_d = 1'b0;
            prio_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        p0_gnt     = gnt_vec[0];
                        p1_gnt     = gnt_vec[1];
                        prio_d     = ~winner;
                        ram_addr_d = winner ? p1_addr : p0_addr;
                        win_cmd    = winner ? p1_cmd : p0_cmd;
                        if (win_cmd == MWRITE) begin
                            ram_we  = 1'b1;
                            ram_din = winner ? p1_wdata : p0_wdata;
                        end else begin
                            state_d = S_RDATA;
                            owner_d = winner;
                        end
                    end
                end
                S_RDATA: begin
                    busy      = 1'b1;
                    p0_rvalid = ~owner_q;
                    p1_rvalid = owner_q;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The bus address is held between transactions so the RAM sees no spurious toggles.
    assign ram_addr = ram_addr_d;
    assign rdata    = ram_dout;
    assign err      = err_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            err_q      <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            err_q      <= err_d;
            ram_addr_q <= ram_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic [1:0]    p0_cmd, p1_cmd;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy, err;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Lab RAM stand-in: synchronous write, one-cycle registered read.
    logic [DW-1:0] tb_ram [0:511];
    always @(posedge clk) begin
        if (ram_we) tb_ram[ram_addr] <= ram_din;
        ram_dout <= tb_ram[ram_addr];
    end

    // Transaction-level model state.
    logic [DW-1:0] mem_m [0:511];
    bit            rd_pend;
    bit            rd_owner;
    logic [AW-1:0] rd_addr;
    bit            prio_m;
    bit            err_m;
    bit [1:0]      last_gnt;

    int tests;
    int fails;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input bit rst,
                        input logic [1:0] c0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [1:0] c1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit r0, r1, w, ewe, ebusy;
        bit [1:0] eg, ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        reset = rst;
        p0_cmd = c0; p0_addr = a0; p0_wdata = d0;
        p1_cmd = c1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
        r0 = (c0 == MREAD) || (c0 == MWRITE);
        r1 = (c1 == MREAD) || (c1 == MWRITE);
        eg = 2'b00; ev = 2'b00; ebusy = 0; ewe = 0; w = 0; ea = '0; ed = '0;
        if (!rst) begin
            if (rd_pend) begin
                ev[rd_owner] = 1'b1;
                ebusy = 1'b1;
            end else if (r0 || r1) begin
                w = (r0 && r1) ? prio_m : r1;
                eg[w] = 1'b1;
                ea = w ? a1 : a0;
                ed = w ? d1 : d0;
                ewe = ((w ? c1 : c0) == MWRITE);
            end
        end
        check("gnt", {p1_gnt, p0_gnt}, eg);
        check("rvalid", {p1_rvalid, p0_rvalid}, ev);
        check("busy", busy, ebusy);
        check("ram_we", ram_we, ewe);
        check("err", err, rst ? 1'b0 : err_m);
        if (eg != 0) check("ram_addr", ram_addr, ea);
        if (ewe) check("ram_din", ram_din, ed);
        if (ev != 0) check("rdata", rdata, mem_m[rd_addr]);
        last_gnt = eg;
        @(posedge clk);
        if (rst) begin
            rd_pend = 0; prio_m = 0; err_m = 0;
        end else begin
            if (c0 == 2'b11 || c1 == 2'b11) err_m = 1;
            if (rd_pend) rd_pend = 0;
            else if (eg != 0) begin
                prio_m = !w;
                if (ewe) mem_m[ea] = ed;
                else begin
                    rd_pend = 1; rd_owner = w; rd_addr = ea;
                end
            end
        end
        #1;
    endtask

    function automatic logic [1:0] rand_cmd();
        int r;
        r = $urandom_range(0, 99);
        if (r < 35) return MNONE;
        if (r < 65) return MREAD;
        if (r < 97) return MWRITE;
        return 2'b11;
    endfunction

    logic [1:0]    hc0, hc1;
    logic [AW-1:0] ha0, ha1;
    logic [DW-1:0] hd0, hd1;

    initial begin
        clk = 0; reset = 1;
        p0_cmd = MNONE; p0_addr = '0; p0_wdata = '0;
        p1_cmd = MNONE; p1_addr = '0; p1_wdata = '0;
        tests = 0; fails = 0;
        rd_pend = 0; rd_owner = 0; rd_addr = '0; prio_m = 0; err_m = 0; last_gnt = 0;
        for (int i = 0; i < 512; i++) begin
            mem_m[i]  = DW'(i * 3 + 7);
            tb_ram[i] = DW'(i * 3 + 7);
        end

        // Reset held with requests present: everything must stay quiet.
        step(1, MREAD, 9'h005, 16'h0, MWRITE, 9'h006, 16'h1111);
        step(1, 2'b11, 9'h005, 16'h0, MNONE, 9'h000, 16'h0);

        // Single-port write then read-back.
        step(0, MWRITE, 9'h010, 16'hABCD, MNONE, 9'h000, 16'h0);
        step(0, MREAD,  9'h010, 16'h0,    MNONE, 9'h000, 16'h0);
        step(0, MNONE,  9'h000, 16'h0,    MNONE, 9'h000, 16'h0);

        // Simultaneous reads: p0 first, p1 holds and follows.
        step(1, MNONE, 9'h000, 16'h0, MNONE, 9'h000, 16'h0);
        step(0, MREAD, 9'h001, 16'h0, MREAD, 9'h002, 16'h0);
        step(0, MNONE, 9'h000, 16'h0, MREAD, 9'h002, 16'h0);
        step(0, MNONE, 9'h000, 16'h0, MREAD, 9'h002, 16'h0);
        step(0, MNONE, 9'h000, 16'h0, MNONE, 9'h000, 16'h0);

        // Back-to-back writes from both ports must alternate.
        hc0 = MWRITE; ha0 = 9'h020; hd0 = 16'h5000;
        hc1 = MWRITE; ha1 = 9'h030; hd1 = 16'h6000;
        for (int k = 0; k < 6; k++) begin
            step(0, hc0, ha0, hd0, hc1, ha1, hd1);
            if (last_gnt[0]) begin ha0 = ha0 + 1; hd0 = hd0 + 16'h0101; end
            if (last_gnt[1]) begin ha1 = ha1 + 1; hd1 = hd1 + 16'h0303; end
        end

        // Reset during RDATA aborts the read and restores CPU priority.
        step(0, MNONE, 9'h000, 16'h0, MREAD, 9'h044, 16'h0);
        step(1, MREAD, 9'h045, 16'h0, MREAD, 9'h046, 16'h0);
        step(0, MREAD, 9'h045, 16'h0, MREAD, 9'h046, 16'h0);
        step(0, MNONE, 9'h000, 16'h0, MREAD, 9'h046, 16'h0);

        // Illegal command: ignored, sticky err until reset.
        step(0, MNONE, 9'h000, 16'h0, MREAD, 9'h046, 16'h0);
        step(0, 2'b11, 9'h011, 16'h0, MNONE, 9'h000, 16'h0);
        step(0, MWRITE, 9'h012, 16'h7777, MNONE, 9'h000, 16'h0);
        step(0, MNONE, 9'h000, 16'h0, MNONE, 9'h000, 16'h0);

        // p1 gives up its read while p0's read is in RDATA.
        step(1, MNONE, 9'h000, 16'h0, MNONE, 9'h000, 16'h0);
        step(0, MREAD, 9'h013, 16'h0, MREAD, 9'h014, 16'h0);
        step(0, MNONE, 9'h000, 16'h0, MNONE, 9'h000, 16'h0);
        step(0, MNONE, 9'h000, 16'h0, MNONE, 9'h000, 16'h0);
        step(0, MWRITE, 9'h015, 16'h1234, MWRITE, 9'h016, 16'h4321);
        step(0, MWRITE, 9'h015, 16'h1234, MNONE, 9'h000, 16'h0);

        // Random traffic: requesters hold until granted, occasionally drop or reset.
        hc0 = MNONE; hc1 = MNONE; ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (last_gnt[0] || !is_req(hc0) || $urandom_range(0, 19) == 0) begin
                hc0 = rand_cmd(); ha0 = AW'($urandom_range(0, 63)); hd0 = DW'($urandom);
            end
            if (last_gnt[1] || !is_req(hc1) || $urandom_range(0, 19) == 0) begin
                hc1 = rand_cmd(); ha1 = AW'($urandom_range(0, 63)); hd1 = DW'($urandom);
            end
            step($urandom_range(0, 99) == 0, hc0, ha0, hd0, hc1, ha1, hd1);
        end
        step(0, MNONE, 9'h000, 16'h0, MNONE, 9'h000, 16'h0);
        step(0, MNONE, 9'h000, 16'h0, MNONE, 9'h000, 16'h0);

        for (int i = 0; i < 64; i++) check("ram_contents", tb_ram[i], mem_m[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port lab RAM between two requesters: port 0 is the CPU (mem_cmd/mem_addr/w_data side) and port 1 is the loader/IO master.
- Arbitration is round-robin with a per-transaction grant.
- Writes complete in 1 cycle; reads complete in 2 cycles because the RAM has a 1-cycle synchronous read.
- Sits between the cpu and the RAM instance in the top level. Each requester holds its command until it sees its grant.

Parameters:
AW, 9, address width (matches the 9-bit mem_addr)
DW, 16, data width (matches r_data/w_data)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
p0_cmd  input  2  port 0 command: MNONE/MREAD/MWRITE
p0_addr  input  AW  port 0 address
p0_wdata  input  DW  port 0 write data
p0_gnt  output  1  port 0 command accepted this cycle
p0_rvalid  output  1  port 0 read data valid this cycle
p1_cmd  input  2  port 1 command
p1_addr  input  AW  port 1 address
p1_wdata  input  DW  port 1 write data
p1_gnt  output  1  port 1 command accepted this cycle
p1_rvalid  output  1  port 1 read data valid this cycle
rdata  output  DW  read data, shared by both ports; qualify with pX_rvalid
ram_addr  output  AW  RAM address
ram_we  output  1  RAM write enable
ram_din  output  DW  RAM write data
ram_dout  input  DW  RAM read data, valid 1 cycle after the address is presented
busy  output  1  high while in RDATA
err  output  1  sticky flag: an illegal command (2'b11) was seen

Behaviour:
- Command encoding: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10. Code 2'b11 is treated as MNONE and sets err; err is cleared only by reset.
- State machine has two states, IDLE and RDATA. Reset state is IDLE.
- Priority pointer prio:
  - prio resets to 0 (CPU favoured).
  - After a grant to port k, prio becomes ~k.
- IDLE arbitration (combinational):
  - A port is requesting when its cmd is MREAD or MWRITE.
  - If exactly one port is requesting, that port wins.
  - If both are requesting, port prio wins.
  - The winner's pX_gnt is 1 in the same cycle. ram_addr takes the winner's addr.
  - Winner cmd MWRITE: ram_we=1 and ram_din=winner wdata. The write completes at that clock edge; stay in IDLE.
  - Winner cmd MREAD: ram_we=0; next state is RDATA; the winner id is registered as owner.
- RDATA:
  - powner_rvalid=1 and rdata=ram_dout.
  - No grants are issued; the losing port waits. Next state is IDLE.
  - A new grant is possible in the following cycle, so reads issue at most every 2 cycles.
- Idle bus: ram_addr holds its last driven value from a register; ram_we=0.
- Lost requests: the loser sees pX_gnt=0 and must hold cmd/addr/wdata stable until it is granted. A requester that drops its cmd before grant is simply not served.
- Reset:
  - All gnt, rvalid, ram_we, busy and err are 0 while reset is high, regardless of inputs.
  - Reset in RDATA aborts the read: no rvalid is generated, state goes to IDLE, prio=0.
- Starvation: with both ports requesting continuously, grants strictly alternate 0,1,0,1…
- Address and data pass through unmodified at full AW/DW width; there is no range checking.

Decomposition:
- Shared include mem_defs.vh: `define MNONE, MREAD, MWRITE, plus the state encodings S_IDLE=1'b0 and S_RDATA=1'b1. The cpu controller is updated to use the same defines.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker with inputs req[1:0] and prio, and outputs gnt_vec[1:0] and winner.
- The state register, owner register and prio register remain in mem_arbiter.

Test Plan:
1. After reset, p0 MWRITE addr 9'h010 data 16'hABCD → p0_gnt=1, ram_we=1, ram_addr=9'h010 in that cycle. Then p0 MREAD 9'h010 → p0_gnt, then the next cycle p0_rvalid=1 with rdata=16'hABCD, busy=1.
2. Both ports MREAD in the same cycle after reset (p0 addr 9'h001, p1 addr 9'h002) → p0 granted first. Cycle after RDATA: p1_gnt=1, and p1_rvalid arrives 2 cycles after p0_rvalid.
3. Both ports issue MWRITE continuously for 6 cycles → grant sequence 0,1,0,1,0,1; ram_we=1 every cycle; the RAM contents match each winner's data.
4. p1 MREAD is granted, then reset is asserted in the RDATA cycle → no p1_rvalid. After release, a simultaneous request grants p0 first (prio=0).
5. p0_cmd=2'b11 for 1 cycle → no grant, ram_we=0, err=1 and stays 1. A later valid request is served normally; err clears only on reset.
6. p1 drops its MREAD while p0 holds a read in RDATA → p1 is never granted, no p1_rvalid; prio reflects only the p0 grant.
